data_io_sync: RTL and testbench

Parametrised, single-clock SPI-slave configuration and download port between the MiST io controller (ARM) and the core. It oversamples the SPI pins in `clk_sys` and decodes the controller command set: ACK, data read-back, config-string read, status word write, file index, and download start/data/end. It adds a configurable download word width and address width, `ioctl_wait` back-pressure and overrun detection. It sits beside `user_io` and feeds the core's ROM/RAM loader.

---
 rtl/data_io_sync.sv | 273 +++++++++++++++++++++++++++
 tb/tb_data_io_sync.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_sync.sv
// data_io_sync
// SPI-slave configuration and download port between the MiST io controller
// and the core. The SPI pins are oversampled in clk_sys and the controller
// command set is decoded: ACK (0x00), data read-back (0x10), config string
// read (0x14), status write (0x15), file index (0x55), address reset (0x60)
// and download start/end (0x61/0x62). Downloaded bytes are packed into DW-bit
// words and handed to the loader through a single holding register.
//
// Ports:
//   clk_sys        system clock, all logic on its rising edge
//   reset          synchronous, active-high
//   SPI_SCK/SS2/DI SPI from the io controller (asynchronous, SS2 active-low)
//   SPI_DO         SPI data out, high-impedance while deselected
//   data_in        byte returned by cmd 0x10
//   conf_str       config string, first character in the MS byte
//   status         menu status word
//   ioctl_download download active
//   ioctl_index    menu file index
//   ioctl_wr       one-cycle write strobe
//   ioctl_addr     word address, valid with ioctl_wr
//   ioctl_dout     word data, valid with ioctl_wr
//   ioctl_wait     sink busy, holds back ioctl_wr
//   ioctl_overrun  sticky flag: a completed word was dropped
module data_io_sync #(
    parameter int STRLEN = 0,
    parameter int DW = 8,
    parameter int AW = 25,
    parameter logic [AW-1:0] START_ADDR = '0
) (
    input  logic                                  clk_sys,
    input  logic                                  reset,
    input  logic                                  SPI_SCK,
    input  logic                                  SPI_SS2,
    input  logic                                  SPI_DI,
    output logic                                  SPI_DO,
    input  logic [7:0]                            data_in,
    input  logic [(STRLEN > 0 ? 8*STRLEN : 8)-1:0] conf_str,
    output logic [31:0]                           status,
    output logic                                  ioctl_download,
    output logic [7:0]                            ioctl_index,
    output logic                                  ioctl_wr,
    output logic [AW-1:0]                         ioctl_addr,
    output logic [DW-1:0]                         ioctl_dout,
    input  logic                                  ioctl_wait,
    output logic                                  ioctl_overrun
);

    localparam logic [7:0] CMD_ACK      = 8'h00;
    localparam logic [7:0] CMD_READ     = 8'h10;
    localparam logic [7:0] CMD_CONF     = 8'h14;
    localparam logic [7:0] CMD_STATUS   = 8'h15;
    localparam logic [7:0] CMD_INDEX    = 8'h55;
    localparam logic [7:0] CMD_ADDR     = 8'h60;
    localparam logic [7:0] CMD_DL_START = 8'h61;
    localparam logic [7:0] CMD_DL_END   = 8'h62;
    localparam logic [AW-1:0] ADDR_ONE  = 1;

    logic          sck_meta, sck_sync, sck_prev;
    logic          ss_meta, ss_sync;
    logic          di_meta, di_sync;
    logic          armed;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_cnt;
    logic [6:0]    rx_sr;
    logic [7:0]    cmd;
    logic [6:0]    tx_sr;
    logic          do_bit;
    logic [7:0]    tx_next;
    logic [7:0]    conf_byte;
    logic          lane;
    logic [7:0]    lo_byte;
    logic          pending;
    logic          end_req;
    logic          word_done;
    logic [DW-1:0] word;

    logic       sck_rise, sck_fall, active;
    logic [7:0] rx_byte, data_k;
    logic       byte_done, cmd_done, data_done, dl_byte;

    assign sck_rise  = sck_sync & ~sck_prev;
    assign sck_fall  = ~sck_sync & sck_prev;
    // After reset the block stays deaf until it has seen SS2 high, so a
    // transfer that was cut by reset is never decoded half-way through.
    assign active    = armed & ~ss_sync;
    assign rx_byte   = {rx_sr, di_sync};
    assign data_k    = byte_cnt - 8'd1;
    assign byte_done = active & sck_rise & (bit_cnt == 3'd7);
    assign cmd_done  = byte_done & (byte_cnt == 8'd0);
    assign data_done = byte_done & (byte_cnt != 8'd0);
    assign dl_byte   = data_done & (cmd == CMD_DL_START);

    assign SPI_DO   = active ? do_bit : 1'bz;
    assign ioctl_wr = pending & ~ioctl_wait;

    // SS2 resets to "selected" so that a select still held low after reset
    // is not mistaken for the start of a fresh frame.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
            ss_meta  <= 1'b0;
            ss_sync  <= 1'b0;
            di_meta  <= 1'b0;
            di_sync  <= 1'b0;
        end else begin
            sck_meta <= SPI_SCK;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
            ss_meta  <= SPI_SS2;
            ss_sync  <= ss_meta;
            di_meta  <= SPI_DI;
            di_sync  <= di_meta;
        end
    end

    // A byte is only visible in the config string while k < STRLEN.
    always_comb begin
        conf_byte = 8'h00;
        for (int i = 0; i < STRLEN; i++) begin
            if (int'(data_k) == i) begin
                conf_byte = conf_str[8*(STRLEN-i)-1 -: 8];
            end
        end
    end

    always_comb begin
        tx_next = 8'h00;
        case (cmd)
            CMD_ACK:  tx_next = 8'h4B;
            CMD_READ: tx_next = data_in;
            CMD_CONF: tx_next = conf_byte;
            default:  tx_next = 8'h00;
        endcase
    end

    // The SCK fall that follows the 8th rise of a byte starts the next
    // byte, so that is where the reply byte is fetched and its MSB driven.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            armed    <= 1'b0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
            rx_sr    <= 7'd0;
            cmd      <= 8'h00;
            tx_sr    <= 7'd0;
            do_bit   <= 1'b0;
        end else begin
            if (ss_sync) begin
                armed <= 1'b1;
            end
            if (!active) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 8'd0;
                tx_sr    <= 7'd0;
                do_bit   <= 1'b0;
            end else if (sck_rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == 8'd0) begin
                        cmd <= rx_byte;
                    end
                    if (byte_cnt != 8'hFF) begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
            end else if (sck_fall) begin
                if (bit_cnt == 3'd0) begin
                    do_bit <= tx_next[7];
                    tx_sr  <= tx_next[6:0];
                end else begin
                    do_bit <= tx_sr[6];
                    tx_sr  <= {tx_sr[5:0], 1'b0};
                end
            end
        end
    end

    // Word assembly: every byte for DW=8, the odd byte for DW=16, or the
    // flush of a lone low byte (upper byte zero) when 0x62 completes.
    always_comb begin
        word_done = 1'b0;
        word      = '0;
        if (dl_byte) begin
            if (DW == 8) begin
                word_done = 1'b1;
                word      = DW'({8'h00, rx_byte});
            end else if (lane) begin
                word_done = 1'b1;
                word      = DW'({rx_byte, lo_byte});
            end
        end else if (cmd_done && (rx_byte == CMD_DL_END) && lane) begin
            word_done = 1'b1;
            word      = DW'({8'h00, lo_byte});
        end
    end

    // A word that completes in the same cycle the previous one retires is
    // accepted; only a completion against a still-blocked word is dropped.
    // When 0x62 leaves a word outstanding, download ends with its strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            status         <= 32'h0;
            ioctl_download <= 1'b0;
            ioctl_index    <= 8'h00;
            ioctl_addr     <= START_ADDR;
            ioctl_dout     <= '0;
            ioctl_overrun  <= 1'b0;
            pending        <= 1'b0;
            end_req        <= 1'b0;
            lane           <= 1'b0;
            lo_byte        <= 8'h00;
        end else begin
            if (ioctl_wr) begin
                pending    <= 1'b0;
                ioctl_addr <= ioctl_addr + ADDR_ONE;
                if (end_req) begin
                    ioctl_download <= 1'b0;
                    end_req        <= 1'b0;
                end
            end
            if (word_done) begin
                if (!pending || ioctl_wr) begin
                    pending    <= 1'b1;
                    ioctl_dout <= word;
                end else begin
                    ioctl_overrun <= 1'b1;
                end
            end
            if (dl_byte && (DW == 16)) begin
                lane <= ~lane;
                if (!lane) begin
                    lo_byte <= rx_byte;
                end
            end
            if (data_done && (cmd == CMD_STATUS)) begin
                case (data_k)
                    8'd0:    status[31:24] <= rx_byte;
                    8'd1:    status[23:16] <= rx_byte;
                    8'd2:    status[15:8]  <= rx_byte;
                    8'd3:    status[7:0]   <= rx_byte;
                    default: ;
                endcase
            end
            if (data_done && (cmd == CMD_INDEX)) begin
                ioctl_index <= rx_byte;
            end
            if (cmd_done) begin
                case (rx_byte)
                    CMD_ADDR: ioctl_addr <= START_ADDR;
                    CMD_DL_START: begin
                        ioctl_download <= 1'b1;
                        ioctl_overrun  <= 1'b0;
                        lane           <= 1'b0;
                        end_req        <= 1'b0;
                    end
                    CMD_DL_END: begin
                        lane <= 1'b0;
                        if (lane || (pending && !ioctl_wr)) begin
                            end_req <= 1'b1;
                        end else begin
                            ioctl_download <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_io_sync.sv
`timescale 1ns/1ps
// Bench for data_io_sync: one 16-bit instance with a 3-byte config string and
// one 8-bit instance with a non-zero start address, sharing SCK/DI and clock.
module tb_data_io_sync;

    localparam int HALF = 50;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        di = 1'b0;
    logic        ss16 = 1'b1;
    logic        ss8 = 1'b1;
    logic        wait16 = 1'b0;
    logic        wait8 = 1'b0;
    logic [7:0]  data_in = 8'h00;

    wire         do16, do8;
    pullup (do16);
    pullup (do8);

    logic [31:0] status16, status8;
    logic        dl16, dl8, wr16, wr8, ovr16, ovr8;
    logic [7:0]  index16, index8;
    logic [24:0] addr16, addr8;
    logic [15:0] dout16;
    logic [7:0]  dout8;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n16 = 0;
    int n8 = 0;
    int wr_in_wait16 = 0;
    int first_wr_cyc16 = -1;
    logic [24:0] la16 [8];
    logic [15:0] ld16 [8];
    logic [24:0] la8 [4];
    logic [7:0]  ld8 [4];
    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    logic [7:0]  scratch;
    int          rel;

    data_io_sync #(.STRLEN(3), .DW(16), .AW(25), .START_ADDR(25'h0)) dut16 (
        .clk_sys(clk_sys), .reset(reset),
        .SPI_SCK(sck), .SPI_SS2(ss16), .SPI_DI(di), .SPI_DO(do16),
        .data_in(data_in), .conf_str(24'h414243),
        .status(status16), .ioctl_download(dl16), .ioctl_index(index16),
        .ioctl_wr(wr16), .ioctl_addr(addr16), .ioctl_dout(dout16),
        .ioctl_wait(wait16), .ioctl_overrun(ovr16)
    );

    data_io_sync #(.STRLEN(2), .DW(8), .AW(25), .START_ADDR(25'h100)) dut8 (
        .clk_sys(clk_sys), .reset(reset),
        .SPI_SCK(sck), .SPI_SS2(ss8), .SPI_DI(di), .SPI_DO(do8),
        .data_in(data_in), .conf_str(16'h5859),
        .status(status8), .ioctl_download(dl8), .ioctl_index(index8),
        .ioctl_wr(wr8), .ioctl_addr(addr8), .ioctl_dout(dout8),
        .ioctl_wait(wait8), .ioctl_overrun(ovr8)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Write log, sampled on the falling edge away from the active edge.
    always @(negedge clk_sys) begin
        if (wr16) begin
            if (n16 == 0) first_wr_cyc16 = cyc;
            if (n16 < 8) begin
                la16[n16] = addr16;
                ld16[n16] = dout16;
            end
            if (wait16) wr_in_wait16++;
            n16++;
        end
        if (wr8) begin
            if (n8 < 4) begin
                la8[n8] = addr8;
                ld8[n8] = dout8;
            end
            n8++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic setSelect(input int tgt, input logic lvl);
        if (tgt == 0) ss16 = lvl;
        else ss8 = lvl;
    endtask

    // Shifts nbits of tx MSB first; DO is sampled just before each rise.
    task automatic spiBits(input int tgt, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            di = tx[i];
            #(HALF);
            rx[i] = (tgt == 0) ? do16 : do8;
            sck = 1'b1;
            #(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int tgt, input int n);
        setSelect(tgt, 1'b0);
        #(2*HALF);
        for (int k = 0; k < n; k++) begin
            spiBits(tgt, tx_buf[k], 8, rx_buf[k]);
        end
        #(HALF);
        setSelect(tgt, 1'b1);
        #(4*HALF);
    endtask

    initial begin
        repeat (5) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;

        $display("[TB] reset values");
        checkOutput("rst_status", status16, 32'h0);
        checkOutput("rst_download", {31'd0, dl16}, 32'd0);
        checkOutput("rst_index", {24'd0, index16}, 32'd0);
        checkOutput("rst_wr", {31'd0, wr16}, 32'd0);
        checkOutput("rst_addr16", {7'd0, addr16}, 32'd0);
        checkOutput("rst_addr8", {7'd0, addr8}, 32'h100);
        checkOutput("rst_dout", {16'd0, dout16}, 32'd0);
        checkOutput("rst_overrun", {31'd0, ovr16}, 32'd0);
        checkOutput("rst_do_z", {31'd0, do16}, 32'd1);

        $display("[TB] ACK");
        tx_buf = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 3);
        checkOutput("ack_b0", {24'd0, rx_buf[1]}, 32'h4B);
        checkOutput("ack_b1", {24'd0, rx_buf[2]}, 32'h4B);

        $display("[TB] read-back");
        data_in = 8'h5A;
        tx_buf = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 2);
        checkOutput("read_data_in", {24'd0, rx_buf[1]}, 32'h5A);

        $display("[TB] status and index");
        tx_buf = '{8'h15, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00};
        applyStimulus(0, 6);
        checkOutput("status_word", status16, 32'hAABBCCDD);
        tx_buf = '{8'h55, 8'h3C, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 3);
        checkOutput("index_last", {24'd0, index16}, 32'h7E);

        $display("[TB] config string");
        tx_buf = '{8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 5);
        checkOutput("conf_k0", {24'd0, rx_buf[1]}, 32'h41);
        checkOutput("conf_k1", {24'd0, rx_buf[2]}, 32'h42);
        checkOutput("conf_k2", {24'd0, rx_buf[3]}, 32'h43);
        checkOutput("conf_k3", {24'd0, rx_buf[4]}, 32'h00);
        checkOutput("do_z_after", {31'd0, do16}, 32'd1);

        $display("[TB] 16-bit download with back-pressure");
        tx_buf = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 1);
        @(posedge clk_sys); #1 wait16 = 1'b1;
        tx_buf = '{8'h61, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 3);
        checkOutput("dl_rise", {31'd0, dl16}, 32'd1);
        checkOutput("held_by_wait", n16, 0);
        @(posedge clk_sys); #1 wait16 = 1'b0;
        rel = cyc;
        repeat (4) @(posedge clk_sys);
        #1;
        checkOutput("wr_latency", first_wr_cyc16, rel);
        checkOutput("wr0_count", n16, 1);
        checkOutput("wr0_addr", {7'd0, la16[0]}, 32'd0);
        checkOutput("wr0_data", {16'd0, ld16[0]}, 32'h2211);
        tx_buf = '{8'h61, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 3);
        tx_buf = '{8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 1);
        checkOutput("wr1_count", n16, 2);
        checkOutput("wr1_addr", {7'd0, la16[1]}, 32'd1);
        checkOutput("wr1_data", {16'd0, ld16[1]}, 32'h4433);
        checkOutput("dl_fall", {31'd0, dl16}, 32'd0);
        checkOutput("no_overrun16", {31'd0, ovr16}, 32'd0);
        checkOutput("wr_while_wait", wr_in_wait16, 0);

        $display("[TB] odd-byte flush");
        tx_buf = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 1);
        tx_buf = '{8'h61, 8'h11, 8'h22, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 4);
        checkOutput("flush_pre_count", n16, 3);
        tx_buf = '{8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(0, 1);
        checkOutput("flush_count", n16, 4);
        checkOutput("flush_w0_data", {16'd0, ld16[2]}, 32'h2211);
        checkOutput("flush_addr", {7'd0, la16[3]}, 32'd1);
        checkOutput("flush_data", {16'd0, ld16[3]}, 32'h0055);
        checkOutput("flush_dl_fall", {31'd0, dl16}, 32'd0);

        $display("[TB] overrun on 8-bit instance");
        @(posedge clk_sys); #1 wait8 = 1'b1;
        tx_buf = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1, 1);
        tx_buf = '{8'h61, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1, 3);
        checkOutput("ovr_set", {31'd0, ovr8}, 32'd1);
        checkOutput("ovr_no_wr", n8, 0);
        @(posedge clk_sys); #1 wait8 = 1'b0;
        repeat (6) @(posedge clk_sys);
        #1;
        checkOutput("ovr_one_wr", n8, 1);
        checkOutput("ovr_wr_addr", {7'd0, la8[0]}, 32'h100);
        checkOutput("ovr_wr_data", {24'd0, ld8[0]}, 32'hA1);
        tx_buf = '{8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1, 1);
        checkOutput("ovr_cleared", {31'd0, ovr8}, 32'd0);
        checkOutput("ovr_still_one", n8, 1);
        tx_buf = '{8'h62, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1, 1);

        $display("[TB] reset mid-transfer and early deselect");
        setSelect(1, 1'b0);
        #(2*HALF);
        spiBits(1, 8'h55, 8, scratch);
        @(posedge clk_sys); #1 reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        spiBits(1, 8'h12, 8, scratch);
        spiBits(1, 8'h34, 8, scratch);
        #(HALF);
        checkOutput("rst_mid_index", {24'd0, index8}, 32'h00);
        checkOutput("rst_mid_addr", {7'd0, addr8}, 32'h100);
        setSelect(1, 1'b1);
        #(4*HALF);
        setSelect(1, 1'b0);
        #(2*HALF);
        spiBits(1, 8'hF0, 4, scratch);
        #(HALF);
        setSelect(1, 1'b1);
        #(4*HALF);
        tx_buf = '{8'h55, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        applyStimulus(1, 2);
        checkOutput("early_desel_index", {24'd0, index8}, 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
